// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner
// Cleans up a raw, bouncing push-button into one-clock advance pulses.
// Pipeline: input synchroniser -> debounce counter -> press/auto-repeat FSM.
// The FSM has three processes: a state register, next-state logic and
// output logic. Its outputs are registered in a separate output register.
module btn_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic enable,
  output logic level,
  output logic pulse,
  output logic held
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s;
  logic [CW-1:0]          db_cnt;
  state_t                 state;
  state_t                 state_next;
  logic [RW-1:0]          rpt_cnt;
  logic [RW-1:0]          rpt_next;
  logic                   pulse_next;
  logic                   held_next;
  logic                   rpt_delay_hit;
  logic                   rpt_period_hit;

  assign s              = sync_chain[SYNC_STAGES-1];
  assign rpt_delay_hit  = (rpt_cnt == RW'(REPEAT_DELAY - 1));
  assign rpt_period_hit = (rpt_cnt == RW'(REPEAT_PERIOD - 1));

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (s != level) begin
      if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level  <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RELEASED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: release has priority, then enable, then repeat timing.
  always_comb begin
    state_next = state;
    case (state)
      RELEASED: begin
        if (level && enable)  state_next = PRESSED;
        else if (level)       state_next = LOCKED;
        else                  state_next = RELEASED;
      end
      PRESSED: begin
        if (!level)                                     state_next = RELEASED;
        else if (!enable)                               state_next = LOCKED;
        else if ((REPEAT_EN != 0) && rpt_delay_hit)     state_next = REPEAT;
        else                                            state_next = PRESSED;
      end
      REPEAT: begin
        if (!level)           state_next = RELEASED;
        else if (!enable)     state_next = LOCKED;
        else                  state_next = REPEAT;
      end
      LOCKED: begin
        if (!level)           state_next = RELEASED;
        else                  state_next = LOCKED;
      end
      default: state_next = RELEASED;
    endcase
  end

  // Output logic: next pulse, held and repeat-counter values for each state.
  always_comb begin
    pulse_next = 1'b0;
    held_next  = 1'b0;
    rpt_next   = rpt_cnt;
    case (state)
      RELEASED: begin
        if (level && enable) begin
          pulse_next = 1'b1;
          rpt_next   = '0;
        end else begin
          rpt_next   = '0;
        end
      end
      PRESSED: begin
        if (!level || !enable) begin
          rpt_next = '0;
        end else if (REPEAT_EN != 0) begin
          if (rpt_delay_hit) begin
            pulse_next = 1'b1;
            held_next  = 1'b1;
            rpt_next   = '0;
          end else begin
            rpt_next   = rpt_cnt + RW'(1);
          end
        end else begin
          rpt_next = rpt_cnt;
        end
      end
      REPEAT: begin
        if (!level || !enable) begin
          rpt_next = '0;
        end else begin
          held_next = 1'b1;
          if (rpt_period_hit) begin
            pulse_next = 1'b1;
            rpt_next   = '0;
          end else begin
            rpt_next   = rpt_cnt + RW'(1);
          end
        end
      end
      LOCKED: begin
        rpt_next = '0;
      end
      default: begin
        rpt_next = '0;
      end
    endcase
  end

  // Register the FSM outputs so pulse and held are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse   <= 1'b0;
      held    <= 1'b0;
      rpt_cnt <= '0;
    end else begin
      pulse   <= pulse_next;
      held    <= held_next;
      rpt_cnt <= rpt_next;
    end
  end

endmodule
